// File: rtl/tachyon_schematic_decoder_pkg.sv
// tachyon_pkg: shared constants for the tachyon manifold front end.
//   - ASCII codes of the schematic alphabet
//   - FSM state encoding (legacy-compatible localparam constants)
//   - byte class enum produced by tachyon_char_classify
//   - geometry helpers derived from the manifold width
package tachyon_pkg;

    localparam logic [7:0] CHAR_DOT   = 8'h2E;
    localparam logic [7:0] CHAR_PIPE  = 8'h7C;
    localparam logic [7:0] CHAR_S     = 8'h53;
    localparam logic [7:0] CHAR_CARET = 8'h5E;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DONE  = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    typedef enum logic [2:0] {
        CLS_EMPTY,
        CLS_ENTER,
        CLS_SPLIT,
        CLS_LF,
        CLS_CR,
        CLS_ILLEGAL
    } char_class_t;

    // Active and empty lines alternate, so a frame has width+1 lines.
    function automatic int line_count(input int width);
        return width + 1;
    endfunction

    // 'S' must sit in the centre column.
    function automatic int start_col(input int width);
        return (width - 1) / 2;
    endfunction

endpackage

// File: rtl/tachyon_schematic_decoder_if.sv
// Byte-stream handshake into the schematic decoder.
//   rx_data  : ASCII byte (master -> slave)
//   rx_valid : rx_data is valid (master -> slave)
//   rx_ready : slave accepts a byte; transfer on rx_valid & rx_ready
interface tachyon_schematic_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/tachyon_schematic_decoder_char_classify.sv
// tachyon_char_classify: combinational byte-to-class decode.
//   byte_in : raw ASCII byte
//   cls     : empty ('.'/'|'), enter ('S'), splitter ('^'), lf, cr or illegal
// Position rules are not applied here so the decode can be shared.
module tachyon_char_classify
    import tachyon_pkg::*;
(
    input  logic [7:0]  byte_in,
    output char_class_t cls
);
    always_comb begin
        cls = CLS_ILLEGAL;
        unique case (byte_in)
            CHAR_DOT,
            CHAR_PIPE:  cls = CLS_EMPTY;
            CHAR_S:     cls = CLS_ENTER;
            CHAR_CARET: cls = CLS_SPLIT;
            CHAR_LF:    cls = CLS_LF;
            CHAR_CR:    cls = CLS_CR;
            default:    cls = CLS_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/tachyon_schematic_decoder.sv
// tachyon_schematic_decoder: validates the ASCII schematic stream and emits
// one-hot character strobes for the manifold simulator.
//   clk, reset_n       : clock, async active-low reset
//   restart            : sync pulse, starts a new frame (wins over a byte)
//   rx                 : byte handshake (slave side)
//   beam_*             : registered one-hot strobes, qualified by beam_in_valid
//   frame_done         : pulse alongside the final LF of the frame
//   err_bad_char/width : sticky error flags, cleared by reset or restart
module tachyon_schematic_decoder
    import tachyon_pkg::*;
#(
    parameter int TACHYON_MANIFOLD_WIDTH = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    tachyon_schematic_decoder_if.slave rx,
    output logic beam_empty,
    output logic beam_enter,
    output logic beam_splitter,
    output logic beam_line_feed,
    output logic beam_in_valid,
    output logic frame_done,
    output logic err_bad_char,
    output logic err_width
);
    localparam int LINE_COUNT = line_count(TACHYON_MANIFOLD_WIDTH);
    localparam int START_COL  = start_col(TACHYON_MANIFOLD_WIDTH);
    localparam int CW         = $clog2(TACHYON_MANIFOLD_WIDTH + 1);
    localparam int LW         = $clog2(LINE_COUNT);

    localparam logic [CW-1:0] COL_MAX   = CW'(TACHYON_MANIFOLD_WIDTH);
    localparam logic [CW-1:0] COL_START = CW'(START_COL);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_COUNT - 1);
    localparam logic [LW-1:0] LINE_TWO  = LW'(2);

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [LW-1:0] line;
    logic          s_seen;

    char_class_t cls;
    logic accept;
    logic e_width, e_bad;
    logic em_empty, em_enter, em_split, em_lf;

    tachyon_char_classify u_classify (
        .byte_in (rx.rx_data),
        .cls     (cls)
    );

    // rx_ready is only ever high in RUN, so no separate state qualifier.
    assign accept = rx.rx_valid & rx.rx_ready & ~restart;

    always_comb begin
        e_width  = 1'b0;
        e_bad    = 1'b0;
        em_empty = 1'b0;
        em_enter = 1'b0;
        em_split = 1'b0;
        em_lf    = 1'b0;
        if (accept) begin
            unique case (cls)
                CLS_EMPTY, CLS_ENTER, CLS_SPLIT: begin
                    // Width check first: it has priority over character legality.
                    if (col == COL_MAX)
                        e_width = 1'b1;
                    else if (cls == CLS_EMPTY)
                        em_empty = 1'b1;
                    else if (cls == CLS_ENTER && line == '0 && col == COL_START && !s_seen)
                        em_enter = 1'b1;
                    else if (cls == CLS_SPLIT && !line[0] && line >= LINE_TWO)
                        em_split = 1'b1;
                    else
                        e_bad = 1'b1;
                end
                CLS_LF: begin
                    if (col != COL_MAX)
                        e_width = 1'b1;
                    else if (line == '0 && !s_seen)
                        e_bad = 1'b1;
                    else
                        em_lf = 1'b1;
                end
                CLS_CR:  ;
                default: e_bad = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_RUN;
            col            <= '0;
            line           <= '0;
            s_seen         <= 1'b0;
            rx.rx_ready    <= 1'b0;
            beam_empty     <= 1'b0;
            beam_enter     <= 1'b0;
            beam_splitter  <= 1'b0;
            beam_line_feed <= 1'b0;
            beam_in_valid  <= 1'b0;
            frame_done     <= 1'b0;
            err_bad_char   <= 1'b0;
            err_width      <= 1'b0;
        end else begin
            // Emit flags are already zero on restart (accept is gated).
            beam_empty     <= em_empty;
            beam_enter     <= em_enter;
            beam_splitter  <= em_split;
            beam_line_feed <= em_lf;
            beam_in_valid  <= em_empty | em_enter | em_split | em_lf;
            frame_done     <= em_lf && (line == LINE_LAST);
            rx.rx_ready    <= (state == ST_RUN);

            if (restart) begin
                state        <= ST_RUN;
                col          <= '0;
                line         <= '0;
                s_seen       <= 1'b0;
                err_bad_char <= 1'b0;
                err_width    <= 1'b0;
                rx.rx_ready  <= 1'b1;
            end else if (e_width || e_bad) begin
                state        <= ST_ERROR;
                err_width    <= err_width | e_width;
                err_bad_char <= err_bad_char | e_bad;
                rx.rx_ready  <= 1'b0;
            end else if (em_empty || em_enter || em_split) begin
                // col < COL_MAX here, so the increment cannot wrap.
                col <= col + CW'(1);
                if (em_enter)
                    s_seen <= 1'b1;
            end else if (em_lf) begin
                col <= '0;
                if (line == LINE_LAST) begin
                    state       <= ST_DONE;
                    rx.rx_ready <= 1'b0;
                end else begin
                    line <= line + LW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_tachyon_schematic_decoder.sv
module tb_tachyon_schematic_decoder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic restart = 1'b0;
    logic beam_empty, beam_enter, beam_splitter, beam_line_feed;
    logic beam_in_valid, frame_done, err_bad_char, err_width;

    int tests = 0;
    int fails = 0;

    string log_s = "";
    int    fd_cnt = 0;
    int    fd_pos = 0;
    int    excl_bad = 0;

    tachyon_schematic_decoder_if rx ();

    tachyon_schematic_decoder #(.TACHYON_MANIFOLD_WIDTH(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .restart        (restart),
        .rx             (rx.slave),
        .beam_empty     (beam_empty),
        .beam_enter     (beam_enter),
        .beam_splitter  (beam_splitter),
        .beam_line_feed (beam_line_feed),
        .beam_in_valid  (beam_in_valid),
        .frame_done     (frame_done),
        .err_bad_char   (err_bad_char),
        .err_width      (err_width)
    );

    always #5 clk = ~clk;

    // Record every delivered strobe as one letter: E, S, ^, L (? = not one-hot).
    always @(negedge clk) begin
        if (beam_in_valid) begin
            case ({beam_empty, beam_enter, beam_splitter, beam_line_feed})
                4'b1000: log_s = {log_s, "E"};
                4'b0100: log_s = {log_s, "S"};
                4'b0010: log_s = {log_s, "^"};
                4'b0001: log_s = {log_s, "L"};
                default: log_s = {log_s, "?"};
            endcase
        end else if (beam_empty | beam_enter | beam_splitter | beam_line_feed) begin
            excl_bad++;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_pos = log_s.len();
        end
    end

    task automatic clear_log();
        log_s = "";
        fd_cnt = 0;
        fd_pos = 0;
    endtask

    task automatic send(input logic [7:0] b);
        bit done = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            rx.rx_data  = b;
            rx.rx_valid = 1'b1;
            if (rx.rx_ready) begin
                @(posedge clk);
                done = 1;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_timeout: byte %h not accepted, rx_ready=%b required 1", b, rx.rx_ready);
        end
    endtask

    task automatic send_str(input string s, input bit gap);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (gap) begin
                @(negedge clk);
                rx.rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic check_log(input string name, input string exp);
        tests++;
        if (log_s != exp) begin
            fails++;
            $display("FAIL %s: strobes got '%s' required '%s'", name, log_s, exp);
        end
    endtask

    task automatic test_reset();
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;
        #12;
        check_bit("reset_rx_ready", rx.rx_ready, 1'b0);
        check_bit("reset_valid", beam_in_valid, 1'b0);
        check_bit("reset_frame_done", frame_done, 1'b0);
        check_bit("reset_err_bad", err_bad_char, 1'b0);
        check_bit("reset_err_width", err_width, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_bit("ready_after_reset", rx.rx_ready, 1'b1);
    endtask

    task automatic test_frame();
        clear_log();
        send_str(".S.\n...\n.^.\n...\n", 0);
        check_log("frame_seq", "ESELEEELE^ELEEEL");
        tests++;
        if (fd_cnt != 1 || fd_pos != 16) begin
            fails++;
            $display("FAIL frame_done: count %0d at strobe %0d, required 1 at 16", fd_cnt, fd_pos);
        end
        check_bit("frame_ready_low", rx.rx_ready, 1'b0);
        check_bit("frame_err_bad", err_bad_char, 1'b0);
        check_bit("frame_err_width", err_width, 1'b0);
        do_restart();
        check_bit("frame_restart_ready", rx.rx_ready, 1'b1);
    endtask

    task automatic test_crlf_toggle();
        clear_log();
        send_str(".S.\r\n...\r\n.^.\r\n...\r\n", 1);
        check_log("crlf_seq", "ESELEEELE^ELEEEL");
        check_bit("crlf_ready_low", rx.rx_ready, 1'b0);
        tests++;
        if (fd_cnt != 1 || fd_pos != 16) begin
            fails++;
            $display("FAIL crlf_frame_done: count %0d at strobe %0d, required 1 at 16", fd_cnt, fd_pos);
        end
        do_restart();
    endtask

    task automatic test_short_line();
        clear_log();
        send_str(".S.\n..\n", 0);
        check_log("short_seq", "ESELEE");
        check_bit("short_err_width", err_width, 1'b1);
        check_bit("short_err_bad", err_bad_char, 1'b0);
        check_bit("short_ready_low", rx.rx_ready, 1'b0);
        do_restart();
        check_bit("short_restart_ready", rx.rx_ready, 1'b1);
        check_bit("short_restart_width", err_width, 1'b0);
        check_bit("short_restart_bad", err_bad_char, 1'b0);
    endtask

    task automatic test_bad_char();
        clear_log();
        send_str("S", 0);
        check_log("bad_s_seq", "");
        check_bit("bad_s_err_bad", err_bad_char, 1'b1);
        check_bit("bad_s_err_width", err_width, 1'b0);
        do_restart();
        clear_log();
        send_str(".x", 0);
        check_log("bad_x_seq", "E");
        check_bit("bad_x_err_bad", err_bad_char, 1'b1);
        do_restart();
    endtask

    task automatic test_odd_caret();
        clear_log();
        send_str(".S.\n.^", 0);
        check_log("odd_caret_seq", "ESELE");
        check_bit("odd_caret_err_bad", err_bad_char, 1'b1);
        check_bit("odd_caret_err_width", err_width, 1'b0);
        do_restart();
    endtask

    task automatic test_async_reset();
        clear_log();
        send(".");
        send("S");
        // 'S' strobe is live now; reset must clear it without a clock edge.
        #2;
        check_bit("pre_reset_enter", beam_enter, 1'b1);
        reset_n = 1'b0;
        #1;
        check_bit("async_valid", beam_in_valid, 1'b0);
        check_bit("async_enter", beam_enter, 1'b0);
        check_bit("async_ready", rx.rx_ready, 1'b0);
        rx.rx_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_log();
        send_str(".S.\n...\n.^.\n...\n", 0);
        check_log("post_reset_seq", "ESELEEELE^ELEEEL");
        check_bit("post_reset_done_ready", rx.rx_ready, 1'b0);
        check_bit("post_reset_err_bad", err_bad_char, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_crlf_toggle();
        test_short_line();
        test_bad_char();
        test_odd_caret();
        test_async_reset();
        tests++;
        if (excl_bad != 0) begin
            fails++;
            $display("FAIL strobe_without_valid: got %0d cycles required 0", excl_bad);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
